// File: rtl/button_event.sv
// Turns a debounced button level into single-cycle press / release / long-press /
// auto-repeat events plus a registered held level. Ignores the input while it is settling.
module button_event #(
  parameter int LONG_COUNT   = 50_000_000,
  parameter int REPEAT_COUNT = 10_000_000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic flag,
  input  logic floating,
  output logic press,
  output logic release_evt,
  output logic long_evt,
  output logic repeat_evt,
  output logic held
);

  localparam int HW = (LONG_COUNT > 2) ? $clog2(LONG_COUNT) : 1;
  localparam int RW = (REPEAT_COUNT > 1) ? $clog2(REPEAT_COUNT + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_COUNT - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [RW-1:0]   rep_cnt, rep_n;
  logic            press_n, release_n, long_n, repeat_n, held_n;
  logic            pressed_lvl;

  assign pressed_lvl = ACTIVE_LOW ? ~flag : flag;

  always_comb begin
    state_n   = state;
    hold_n    = hold_cnt;
    rep_n     = rep_cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    case (state)
      IDLE: begin
        if (!floating && pressed_lvl) begin
          press_n = 1'b1;
          hold_n  = '0;
          state_n = PRESSED;
        end
      end
      PRESSED: begin
        if (!floating) begin
          if (!pressed_lvl) begin
            release_n = 1'b1;
            state_n   = IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            long_n  = 1'b1;
            rep_n   = '0;
            state_n = REPEAT;
          end else begin
            hold_n = hold_cnt + HW'(1);
          end
        end
      end
      REPEAT: begin
        if (!floating) begin
          if (!pressed_lvl) begin
            release_n = 1'b1;
            state_n   = IDLE;
          end else if (rep_cnt == REP_LAST) begin
            repeat_n = 1'b1;
            rep_n    = '0;
          end else begin
            rep_n = rep_cnt + RW'(1);
          end
        end
      end
      // illegal encoding: fall back to IDLE regardless of input stability
      default: state_n = IDLE;
    endcase
    held_n = (state_n == PRESSED) || (state_n == REPEAT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_evt    <= 1'b0;
      repeat_evt  <= 1'b0;
      held        <= 1'b0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_n;
      rep_cnt     <= rep_n;
      press       <= press_n;
      release_evt <= release_n;
      long_evt    <= long_n;
      repeat_evt  <= repeat_n;
      held        <= held_n;
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Directed + randomised bench for button_event: an active-low build (8/4) and an
// active-high build (3/1) share stimulus and are checked against an event-count model.
module tb_button_event;

  logic clk = 1'b0;
  logic rst, flag, flag1, floating;
  logic p0, r0, l0, q0, h0;
  logic p1, r1, l1, q1, h1;
  int   tests = 0, fails = 0;

  // model: per build, whether a press is active and stable edges since the press edge
  bit       act  [2];
  int       n    [2];
  logic [4:0] mexp [2];
  int       npress [2], nrel [2];

  always #5 clk = ~clk;

  button_event #(.LONG_COUNT(8), .REPEAT_COUNT(4), .ACTIVE_LOW(1'b1)) dut0 (
    .clk(clk), .rst(rst), .flag(flag), .floating(floating),
    .press(p0), .release_evt(r0), .long_evt(l0), .repeat_evt(q0), .held(h0));

  button_event #(.LONG_COUNT(3), .REPEAT_COUNT(1), .ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .rst(rst), .flag(flag1), .floating(floating),
    .press(p1), .release_evt(r1), .long_evt(l1), .repeat_evt(q1), .held(h1));

  wire [4:0] out0 = {p0, r0, l0, q0, h0};
  wire [4:0] out1 = {p1, r1, l1, q1, h1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; n[k] = 0; mexp[k] = '0;
    end
  endtask

  // outputs are {press, release, long, repeat, held}
  task automatic mdl(input int k, input bit lvl, input bit flt, input int lc, input int rc);
    logic [3:0] pulses;
    pulses = '0;
    if (!flt) begin
      if (!act[k]) begin
        if (lvl) begin act[k] = 1; n[k] = 0; pulses[3] = 1'b1; end
      end else if (!lvl) begin
        act[k] = 0; pulses[2] = 1'b1;
      end else begin
        n[k]++;
        if (n[k] == lc) pulses[1] = 1'b1;
        else if (n[k] > lc && (n[k] - lc) % rc == 0) pulses[0] = 1'b1;
      end
    end
    if (pulses[3]) npress[k]++;
    if (pulses[2]) nrel[k]++;
    mexp[k] = {pulses, act[k]};
  endtask

  // f is the active-low level for dut0; dut1 sees the inverted (active-high) level
  task automatic step(input bit f, input bit fl);
    flag = f; flag1 = ~f; floating = fl;
    @(posedge clk);
    mdl(0, ~f, fl, 8, 4);
    mdl(1, ~f, fl, 3, 1);
    #1;
    chk("model0", 32'(out0), 32'(mexp[0]));
    chk("model1", 32'(out1), 32'(mexp[1]));
    chk("onehot0", 32'($countones(out0[4:1]) <= 1), 32'd1);
    chk("onehot1", 32'($countones(out1[4:1]) <= 1), 32'd1);
  endtask

  initial begin
    npress[0] = 0; npress[1] = 0; nrel[0] = 0; nrel[1] = 0;
    mdl_reset();
    rst = 1'b0; flag = 1'b1; flag1 = 1'b0; floating = 1'b0;
    #12;
    chk("reset0", 32'(out0), 32'd0);
    chk("reset1", 32'(out1), 32'd0);
    rst = 1'b1;
    step(1, 0); step(1, 0);

    // short press: 3 stable pressed edges, then release
    step(0, 0);
    chk("short_press", 32'(p0), 32'd1);
    chk("short_press1", 32'(p1), 32'd1);
    chk("short_held", 32'(h0), 32'd1);
    step(0, 0); step(0, 0);
    step(1, 0);
    chk("short_rel", 32'(r0), 32'd1);
    chk("short_heldoff", 32'(h0), 32'd0);
    step(1, 0);

    // long hold: press at i=0, long at 8, repeats at 12/16/20
    for (int i = 0; i <= 20; i++) begin
      step(0, 0);
      chk("hold_press", 32'(p0), 32'(i == 0));
      chk("hold_long", 32'(l0), 32'(i == 8));
      chk("hold_rep", 32'(q0), 32'(i == 12 || i == 16 || i == 20));
    end
    step(1, 0);
    chk("hold_rel", 32'(r0), 32'd1);
    step(1, 0);

    // floating for 5 edges between press and long delays long by exactly 5
    step(0, 0);
    for (int e = 1; e <= 14; e++) begin
      if (e >= 4 && e <= 8) begin
        step(1'($urandom_range(0, 1)), 1);
        chk("float_quiet", 32'(out0[4:1]), 32'd0);
        chk("float_held", 32'(h0), 32'd1);
      end else begin
        step(0, 0);
        chk("float_long", 32'(l0), 32'(e == 13));
      end
    end
    step(1, 0); step(1, 0);

    // release on the edge where long would have fired
    step(0, 0);
    for (int i = 1; i <= 7; i++) step(0, 0);
    step(1, 0);
    chk("race_rel", 32'(r0), 32'd1);
    chk("race_long", 32'(l0), 32'd0);
    chk("race_held", 32'(h0), 32'd0);
    step(1, 0);

    // async reset mid-REPEAT, then reset released with button still held
    step(0, 0);
    for (int i = 1; i <= 14; i++) step(0, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst0", 32'(out0), 32'd0);
    chk("arst1", 32'(out1), 32'd0);
    mdl_reset();
    #1 rst = 1'b1;
    step(0, 0);
    chk("arst_press", 32'(p0), 32'd1);
    chk("arst_press1", 32'(p1), 32'd1);
    step(1, 0); step(1, 0);

    // randomised bounce and settling
    npress[0] = 0; npress[1] = 0; nrel[0] = 0; nrel[1] = 0;
    begin
      bit lvl = 1;
      for (int i = 0; i < 3000; i++) begin
        bit fl = ($urandom_range(0, 99) < 20);
        if ($urandom_range(0, 99) < (fl ? 50 : 12)) lvl = ~lvl;
        step(lvl, fl);
      end
    end
    step(1, 0); step(1, 0);
    chk("bal0", 32'(npress[0] == nrel[0]), 32'd1);
    chk("bal1", 32'(npress[1] == nrel[1]), 32'd1);
    chk("idle0", 32'(h0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
